cpu_retire_monitor: RTL and testbench

- Other end of the CPU instruction interface: the driver side pushes instructions in, and this block captures each retired instruction as the tuple (pc, instr, result).
- Classifies each retired instruction by RV32I opcode and checks PC sequencing.
- Buffers records in a first-word-fall-through FIFO that the UVM monitor/scoreboard drains through a valid/ready port.
- Sits beside the CPU in the testbench top, clocked by the same clk.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/retire_fifo.sv | 72 +++++++
 rtl/cpu_retire_monitor.sv | 119 +++++++++++
 tb/tb_cpu_retire_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the CPU retire monitor.
//   instr_class_e : coarse RV32I instruction class derived from the opcode
//   OPC_*         : RV32I major opcodes (instr[6:0])
//   retire_rec_t  : one buffered retire record (pc, instr, result, class, seq_err)
//   classify()    : opcode -> instr_class_e
//   is_control()  : true for classes that may legally redirect the PC
package cpu_pkg;

  typedef enum logic [2:0] {
    CL_ALU_R   = 3'd0,
    CL_ALU_I   = 3'd1,
    CL_LOAD    = 3'd2,
    CL_STORE   = 3'd3,
    CL_BRANCH  = 3'd4,
    CL_JUMP    = 3'd5,
    CL_UPPER   = 3'd6,
    CL_ILLEGAL = 3'd7
  } instr_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [31:0]  result;
    instr_class_e cls;
    logic         seq_err;
  } retire_rec_t;

  function automatic instr_class_e classify(input logic [6:0] opc);
    instr_class_e c;
    case (opc)
      OPC_OP:             c = CL_ALU_R;
      OPC_OP_IMM:         c = CL_ALU_I;
      OPC_LOAD:           c = CL_LOAD;
      OPC_STORE:          c = CL_STORE;
      OPC_BRANCH:         c = CL_BRANCH;
      OPC_JAL, OPC_JALR:  c = CL_JUMP;
      OPC_LUI, OPC_AUIPC: c = CL_UPPER;
      default:            c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic logic is_control(input instr_class_e c);
    return (c == CL_BRANCH) || (c == CL_JUMP);
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// retire_fifo: generic first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   wr_valid, wr_data   : write request and payload
//   wr_accept           : the write is taken this cycle (not full, or full with a pop)
//   rd_valid, rd_data   : head present / head payload (all zeros while empty)
//   rd_ready            : consumer takes the head; ignored while empty
//   count               : occupancy, 0..DEPTH
module retire_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_accept,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full/empty come from the occupancy counter so the pointers can simply
  // wrap modulo DEPTH. A pop frees a slot in the same cycle, which is what
  // lets a write into a full FIFO succeed when the consumer is draining.
  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign pop       = rd_ready & ~empty;
  assign push      = wr_valid & (~full | pop);
  assign wr_accept = push;

  // Storage has no reset: stale entries are never visible because the
  // head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign count    = count_q;

endmodule

// File: rtl/cpu_retire_monitor.sv
// cpu_retire_monitor: captures retired instructions (pc, instr, result),
// classifies them by RV32I opcode, flags PC sequencing breaks and buffers
// the records in a FWFT FIFO drained through a valid/ready port.
//   clk, rst                           : clock, asynchronous active-low reset
//   ret_valid/pc/instr/result          : incoming retire record
//   out_valid/ready                    : FIFO head handshake
//   out_pc/instr/result/class/seq_err  : head record (zeros while empty)
//   count                              : FIFO occupancy
//   overflow, drop_cnt                 : sticky drop flag, saturating drop count
//   clr_status                         : synchronous clear of overflow/drop_cnt
module cpu_retire_monitor
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [31:0]              ret_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_result,
  output logic [2:0]               out_class,
  output logic                     out_seq_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_status
);

  instr_class_e cur_class;
  logic         cur_seq_err;
  logic         push_ok;
  logic         drop;
  retire_rec_t  wr_rec;
  retire_rec_t  head_rec;

  logic [31:0]  prev_pc;
  instr_class_e prev_class;
  logic         prev_valid;

  // A record breaks sequencing when the previous one could not redirect
  // the PC yet this PC is not the fall-through address (wraps mod 2^32).
  always_comb begin
    cur_class   = classify(ret_instr[6:0]);
    cur_seq_err = prev_valid && !is_control(prev_class) &&
                  (ret_pc != (prev_pc + 32'd4));
    wr_rec         = '0;
    wr_rec.pc      = ret_pc;
    wr_rec.instr   = ret_instr;
    wr_rec.result  = ret_result;
    wr_rec.cls     = cur_class;
    wr_rec.seq_err = cur_seq_err;
  end

  // The checker follows every retire, including ones the FIFO drops, so
  // that a drop does not produce a spurious break on the next record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc    <= '0;
      prev_class <= CL_ALU_R;
      prev_valid <= 1'b0;
    end else if (ret_valid) begin
      prev_pc    <= ret_pc;
      prev_class <= cur_class;
      prev_valid <= 1'b1;
    end
  end

  retire_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(retire_rec_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (ret_valid),
    .wr_data   (wr_rec),
    .wr_accept (push_ok),
    .rd_valid  (out_valid),
    .rd_ready  (out_ready),
    .rd_data   (head_rec),
    .count     (count)
  );

  assign drop = ret_valid & ~push_ok;

  // Drop accounting. A drop in the same cycle as a clear takes priority,
  // so the clear never hides a freshly lost record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_status) begin
        drop_cnt <= DROP_W'(1);
      end else if (drop_cnt != {DROP_W{1'b1}}) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end else if (clr_status) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  always_comb begin
    out_pc      = head_rec.pc;
    out_instr   = head_rec.instr;
    out_result  = head_rec.result;
    out_class   = head_rec.cls;
    out_seq_err = head_rec.seq_err;
  end

endmodule

// File: tb/tb_cpu_retire_monitor.sv
// tb_cpu_retire_monitor: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the retire monitor.
module tb_cpu_retire_monitor;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int MAXD   = (1 << DROP_W) - 1;
  localparam logic [31:0] ADDI = 32'h0050_0093;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ret_valid = 1'b0;
  logic [31:0]       ret_pc = '0;
  logic [31:0]       ret_instr = '0;
  logic [31:0]       ret_result = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [31:0]       out_result;
  logic [2:0]        out_class;
  logic              out_seq_err;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              clr_status = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [2:0]  cls;
    logic        seq;
  } exp_rec_t;

  exp_rec_t    mq[$];
  int          m_drop;
  bit          m_ovf;
  bit          m_pv;
  logic [31:0] m_ppc;
  bit          m_pctl;

  cpu_retire_monitor #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_instr(ret_instr), .ret_result(ret_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_result(out_result), .out_class(out_class), .out_seq_err(out_seq_err),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_class(input logic [31:0] instr);
    case (instr[6:0])
      7'h33:        return 3'd0;
      7'h13:        return 3'd1;
      7'h03:        return 3'd2;
      7'h23:        return 3'd3;
      7'h63:        return 3'd4;
      7'h6F, 7'h67: return 3'd5;
      7'h37, 7'h17: return 3'd6;
      default:      return 3'd7;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    m_drop = 0; m_ovf = 0; m_pv = 0; m_ppc = '0; m_pctl = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, idle inputs at +1.
  task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] res, input bit rdy, input bit clr);
    exp_rec_t r;
    bit pop;
    bit push;
    ret_valid = v; ret_pc = pc; ret_instr = instr; ret_result = res;
    out_ready = rdy; clr_status = clr;
    pop  = rdy && (mq.size() > 0);
    push = v && ((mq.size() < DEPTH) || pop);
    r.pc = pc; r.instr = instr; r.result = res; r.cls = ref_class(instr);
    r.seq = m_pv && !m_pctl && (pc != m_ppc + 32'd4);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(r);
    if (v && !push) begin
      m_ovf = 1;
      m_drop = clr ? 1 : ((m_drop == MAXD) ? MAXD : m_drop + 1);
    end else if (clr) begin
      m_ovf = 0; m_drop = 0;
    end
    if (v) begin
      m_pv = 1; m_ppc = pc; m_pctl = (r.cls == 3'd4) || (r.cls == 3'd5);
    end
    #1;
    ret_valid = 0; out_ready = 0; clr_status = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    model_clear();
    #4;
    rst = 1;
  endtask

  task automatic test_reset();
    model_clear();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("[TB] FAIL reset_status: got ovf=%0b drop=%0d expected 0/0", overflow, drop_cnt); end
    checks++; if (out_pc !== '0 || out_result !== '0) begin errors++; $display("[TB] FAIL reset_data: got pc=%h res=%h expected 0", out_pc, out_result); end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    cycle(1, 32'h0, ADDI, 32'h5, 0, 0);
    checks++; if (out_valid !== 1'b1 || count !== CW'(1)) begin errors++; $display("[TB] FAIL single_push: got valid=%0b count=%0d expected 1/1", out_valid, count); end
    checks++; if (out_class !== 3'd1 || out_seq_err !== 1'b0) begin errors++; $display("[TB] FAIL single_class: got cls=%0d seq=%0b expected 1/0", out_class, out_seq_err); end
    checks++; if (out_result !== 32'h5) begin errors++; $display("[TB] FAIL single_result: got %h expected 5", out_result); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== '0 || out_pc !== '0) begin errors++; $display("[TB] FAIL single_pop: got valid=%0b count=%0d pc=%h expected 0/0/0", out_valid, count, out_pc); end
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'(4*i), ADDI, 32'(5*(i+1)), 0, 0);
    checks++; if (count !== CW'(3)) begin errors++; $display("[TB] FAIL order_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_result !== 32'(5*(i+1)) || out_seq_err !== 1'b0) begin
        errors++; $display("[TB] FAIL order_head%0d: got v=%0b pc=%h res=%h seq=%0b expected 1/%h/%h/0", i, out_valid, out_pc, out_result, out_seq_err, 4*i, 5*(i+1));
      end
      cycle(0, 0, 0, 0, 1, 0);
    end
    checks++; if (count !== '0) begin errors++; $display("[TB] FAIL order_empty: got %0d expected 0", count); end
  endtask

  task automatic test_seq_check();
    logic [31:0] pcs [4];
    logic [31:0] ins [4];
    logic [2:0]  cls [4];
    logic        seq [4];
    pcs = '{32'h0, 32'h10, 32'h20, 32'h28};
    ins = '{32'h0000_0033, 32'h0011_2023, 32'h0000_0463, ADDI};
    cls = '{3'd0, 3'd3, 3'd4, 3'd1};
    seq = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, pcs[i], ins[i], 32'(i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_pc !== pcs[i] || out_class !== cls[i] || out_seq_err !== seq[i]) begin
        errors++; $display("[TB] FAIL seq_rec%0d: got pc=%h cls=%0d seq=%0b expected %h/%0d/%0b", i, out_pc, out_class, out_seq_err, pcs[i], cls[i], seq[i]);
      end
      cycle(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 19; i++) cycle(1, 32'(4*i), ADDI, 32'(i), 0, 0);
    checks++; if (count !== CW'(16) || overflow !== 1'b1 || drop_cnt !== DROP_W'(3)) begin errors++; $display("[TB] FAIL ovf_fill: got count=%0d ovf=%0b drop=%0d expected 16/1/3", count, overflow, drop_cnt); end
    cycle(1, 32'd76, ADDI, 32'd99, 1, 0);
    checks++; if (count !== CW'(16) || drop_cnt !== DROP_W'(3) || out_pc !== 32'h4) begin errors++; $display("[TB] FAIL ovf_pushpop: got count=%0d drop=%0d head=%h expected 16/3/4", count, drop_cnt, out_pc); end
    cycle(0, 0, 0, 0, 0, 1);
    checks++; if (overflow !== 1'b0 || drop_cnt !== '0) begin errors++; $display("[TB] FAIL ovf_clear: got ovf=%0b drop=%0d expected 0/0", overflow, drop_cnt); end
    cycle(1, 32'd80, ADDI, 0, 0, 1);
    checks++; if (overflow !== 1'b1 || drop_cnt !== DROP_W'(1)) begin errors++; $display("[TB] FAIL ovf_clr_vs_drop: got ovf=%0b drop=%0d expected 1/1", overflow, drop_cnt); end
    for (int i = 0; i < 20; i++) cycle(1, 32'(84 + 4*i), ADDI, 0, 0, 0);
    checks++; if (drop_cnt !== DROP_W'(MAXD)) begin errors++; $display("[TB] FAIL ovf_saturate: got %0d expected %0d", drop_cnt, MAXD); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_pc !== ((i < 15) ? 32'(4*(i+1)) : 32'd76) || out_result !== ((i < 15) ? 32'(i+1) : 32'd99)) begin
        errors++; $display("[TB] FAIL ovf_drain%0d: got pc=%h res=%h", i, out_pc, out_result);
      end
      cycle(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_wrap_illegal();
    do_reset();
    cycle(1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd7, 0, 0);
    cycle(1, 32'h0, ADDI, 32'd8, 0, 0);
    checks++; if (out_class !== 3'd7 || out_seq_err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_class: got cls=%0d seq=%0b expected 7/0", out_class, out_seq_err); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (out_pc !== 32'h0 || out_class !== 3'd1 || out_seq_err !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pc_wrap: got pc=%h cls=%0d seq=%0b expected 0/1/0", out_pc, out_class, out_seq_err); end
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 32'(4*i), ADDI, 0, 0, 0);
    checks++; if (count !== CW'(5)) begin errors++; $display("[TB] FAIL midrst_pre: got %0d expected 5", count); end
    #2;
    rst = 0;
    model_clear();
    #1;
    checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("[TB] FAIL midrst_async: got valid=%0b count=%0d expected 0/0", out_valid, count); end
    #1;
    rst = 1;
    cycle(1, 32'h100, ADDI, 0, 0, 0);
    checks++; if (out_seq_err !== 1'b0 || out_pc !== 32'h100) begin errors++; $display("[TB] FAIL midrst_first: got seq=%0b pc=%h expected 0/100", out_seq_err, out_pc); end
    cycle(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [6:0] opcs [10];
    logic [31:0] pc;
    bit v, rdy, clr;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = (n % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 40) == 0);
      pc  = ($urandom_range(0, 3) != 0) ? m_ppc + 32'd4 : {$urandom(), 2'b00} >> 2 << 2;
      cycle(v, pc, {$urandom() >> 7, opcs[$urandom_range(0, 9)]}, $urandom(), rdy, clr);
      checks++;
      if (out_valid !== (mq.size() != 0) || count !== CW'(mq.size()) || overflow !== m_ovf || drop_cnt !== DROP_W'(m_drop)) begin
        errors++; $display("[TB] FAIL rnd_status@%0d: got v=%0b cnt=%0d ovf=%0b drop=%0d expected %0b/%0d/%0b/%0d", n, out_valid, count, overflow, drop_cnt, mq.size() != 0, mq.size(), m_ovf, m_drop);
      end
      checks++;
      if (mq.size() != 0) begin
        if (out_pc !== mq[0].pc || out_instr !== mq[0].instr || out_result !== mq[0].result || out_class !== mq[0].cls || out_seq_err !== mq[0].seq) begin
          errors++; $display("[TB] FAIL rnd_head@%0d: got %h/%h/%h/%0d/%0b expected %h/%h/%h/%0d/%0b", n, out_pc, out_instr, out_result, out_class, out_seq_err, mq[0].pc, mq[0].instr, mq[0].result, mq[0].cls, mq[0].seq);
        end
      end else if (out_pc !== '0 || out_instr !== '0 || out_result !== '0) begin
        errors++; $display("[TB] FAIL rnd_empty@%0d: got pc=%h instr=%h res=%h expected 0", n, out_pc, out_instr, out_result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_seq_check();
    test_overflow();
    test_wrap_illegal();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
